// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - arbitrates ALU and load writebacks onto the single regfile write port
// Also keeps the per-register pending scoreboard that decode uses for RAW stalls.
module regfile_wb_arbiter #(
    parameter int ADDR_WIDTH   = 5,
    parameter int DATA_WIDTH   = 64,
    parameter int NUM_REGS     = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_wb_valid,
    input  logic [ADDR_WIDTH-1:0] alu_wb_addr,
    input  logic [DATA_WIDTH-1:0] alu_wb_data,
    output logic                  alu_wb_ready,
    input  logic                  mem_wb_valid,
    input  logic [ADDR_WIDTH-1:0] mem_wb_addr,
    input  logic [DATA_WIDTH-1:0] mem_wb_data,
    output logic                  mem_wb_ready,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  rf_write_enable,
    output logic [ADDR_WIDTH-1:0] rf_write_addr,
    output logic [DATA_WIDTH-1:0] rf_write_data,
    output logic [NUM_REGS-1:0]   busy_bits
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic {
        PRIO_MEM,
        PRIO_ALU
    } prio_t;

    prio_t                 prio;
    logic [CNT_W-1:0]      starve_cnt;
    logic [CNT_W-1:0]      cnt_next;
    logic                  alu_grant;
    logic                  mem_grant;
    logic                  any_grant;
    logic                  write_go;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_data;
    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   busy_next;

    always_comb begin
        alu_grant = alu_wb_valid && ((prio == PRIO_ALU) || !mem_wb_valid);
        mem_grant = mem_wb_valid && !alu_grant;
        any_grant = alu_grant || mem_grant;
        win_addr  = alu_grant ? alu_wb_addr : mem_wb_addr;
        win_data  = alu_grant ? alu_wb_data : mem_wb_data;
        // Register 0 is hardwired: accept the request but never write it.
        write_go  = any_grant && (win_addr != '0);
    end

    assign alu_wb_ready = alu_grant;
    assign mem_wb_ready = mem_grant;

    always_comb begin
        cnt_next = '0;
        if (alu_wb_valid && !alu_grant) begin
            cnt_next = (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio            <= PRIO_MEM;
            starve_cnt      <= '0;
            rf_write_enable <= 1'b0;
            rf_write_addr   <= '0;
            rf_write_data   <= '0;
        end else begin
            starve_cnt      <= cnt_next;
            rf_write_enable <= write_go;
            if (write_go) begin
                rf_write_addr <= win_addr;
                rf_write_data <= win_data;
            end
            case (prio)
                PRIO_MEM: if (cnt_next == LIMIT) prio <= PRIO_ALU;
                PRIO_ALU: if (alu_grant || !alu_wb_valid) prio <= PRIO_MEM;
                default:  prio <= PRIO_MEM;
            endcase
        end
    end

    // A new issue to the same register outranks the clear from an older producer.
    always_comb begin
        busy_next = busy;
        if (write_go) busy_next[win_addr] = 1'b0;
        if (issue_valid && (issue_rd != '0)) busy_next[issue_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign busy_bits = busy;
    assign rs1_busy  = busy[rs1_addr];
    assign rs2_busy  = busy[rs2_addr];
endmodule
